// File: rtl/led_status_pkg.sv
// Shared types and LED constants for the countdown status LED driver.
package led_status_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_COUNT,
        ST_WARN,
        ST_BOOM
    } led_state_t;

    localparam logic [3:0] LEDS_OFF  = 4'b0000;
    localparam logic [3:0] LEDS_ALL  = 4'b1111;
    localparam logic [3:0] WALK_SEED = 4'b0001;

    // One step of the walking light: rotate left by one position.
    function automatic logic [3:0] walk_step(input logic [3:0] walk);
        return {walk[2:0], walk[3]};
    endfunction

endpackage

// File: rtl/countdown_led_driver_blink_prescaler.sv
// Blink prescaler: counts 0..BLINK_HALF-1 and flips phase on each wrap.
// A restart clears the count and forces phase lit so the first flash after
// a state change is always a full half-period on.
module blink_prescaler #(
    parameter int BLINK_HALF = 1500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase,
    output logic toggle_pulse
);

    localparam int CW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap         = (cnt == CNT_LAST);
    // High in the cycle whose closing edge flips phase; suppressed by restart.
    assign toggle_pulse = wrap && !restart;

    // Half-period counter and phase flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_led_driver.sv
// Countdown status LED driver: maps the countdown value and critical flag to
// one of five registered LED patterns, with a latched terminal alarm that
// only an operator acknowledge at count zero clears.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | count zero, not armed: LEDs off
// ST_ARMED | count zero, armed: walking light
// ST_COUNT | count 1..CNT_MAX-4: binary value, steady
// ST_WARN  | count CNT_MAX-3..CNT_MAX-1: value blinking
// ST_BOOM  | terminal reached: all LEDs flashing until ack at count zero
module countdown_led_driver
    import led_status_pkg::*;
#(
    parameter int BLINK_HALF = 1500000,
    parameter int CNT_MAX    = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cnt_in,
    input  logic       armed,
    input  logic       ack,
    output logic [3:0] leds,
    output logic       boom
);

    localparam logic [3:0] CNT_TERM    = 4'(CNT_MAX);
    localparam logic [3:0] CNT_WARN_LO = 4'(CNT_MAX - 3);

    led_state_t state, next_state;
    logic       restart;
    logic       phase, toggle_pulse, phase_next;
    logic [3:0] walk, walk_next, leds_next;

    blink_prescaler #(.BLINK_HALF(BLINK_HALF)) u_prescaler (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .phase        (phase),
        .toggle_pulse (toggle_pulse)
    );

    // Next state by priority; BOOM is latched until ack at count zero.
    always_comb begin
        next_state = state;
        if (state == ST_BOOM) begin
            next_state = (ack && cnt_in == 4'd0) ? ST_IDLE : ST_BOOM;
        end else if (cnt_in >= CNT_TERM) begin
            next_state = ST_BOOM;
        end else if (cnt_in >= CNT_WARN_LO) begin
            next_state = ST_WARN;
        end else if (cnt_in != 4'd0) begin
            next_state = ST_COUNT;
        end else begin
            next_state = armed ? ST_ARMED : ST_IDLE;
        end
    end

    assign restart    = (next_state != state);
    assign phase_next = restart ? 1'b1 : (phase ^ toggle_pulse);

    // Pattern for the next cycle, built from the values the prescaler and
    // walk register will hold after this edge so outputs track with one cycle latency.
    always_comb begin
        walk_next = walk;
        leds_next = LEDS_OFF;
        if (next_state == ST_ARMED) begin
            if (state != ST_ARMED) begin
                walk_next = WALK_SEED;
            end else if (toggle_pulse) begin
                walk_next = walk_step(walk);
            end
        end
        case (next_state)
            ST_IDLE:  leds_next = LEDS_OFF;
            ST_ARMED: leds_next = walk_next;
            ST_COUNT: leds_next = cnt_in;
            ST_WARN:  leds_next = phase_next ? cnt_in : LEDS_OFF;
            ST_BOOM:  leds_next = phase_next ? LEDS_ALL : LEDS_OFF;
            default:  leds_next = LEDS_OFF;
        endcase
    end

    // State, walk pattern and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            walk  <= WALK_SEED;
            leds  <= LEDS_OFF;
            boom  <= 1'b0;
        end else begin
            state <= next_state;
            walk  <= walk_next;
            leds  <= leds_next;
            boom  <= (next_state == ST_BOOM);
        end
    end

endmodule

// File: tb/tb_countdown_led_driver.sv
// Testbench for countdown_led_driver: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a model
// that derives the LED pattern from the time spent in the current mode.
module tb_countdown_led_driver;

    localparam int BH = 4;
    localparam int CM = 10;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_COUNT = 2;
    localparam int M_WARN  = 3;
    localparam int M_BOOM  = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic [3:0] cnt_in = 4'd0;
    logic       armed  = 1'b0;
    logic       ack    = 1'b0;
    logic [3:0] leds;
    logic       boom;

    int checks = 0;
    int errors = 0;

    int         m_mode;
    int         m_ns;
    int         m_k;
    logic [3:0] exp_leds;
    logic       exp_boom;

    always #5 clk = ~clk;

    countdown_led_driver #(.BLINK_HALF(BH), .CNT_MAX(CM)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt_in (cnt_in),
        .armed  (armed),
        .ack    (ack),
        .leds   (leds),
        .boom   (boom)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int mode_rule(input int cur, input int c, input bit a, input bit k);
        if (cur == M_BOOM) return (k && c == 0) ? M_IDLE : M_BOOM;
        if (c >= CM)       return M_BOOM;
        if (c >= CM - 3)   return M_WARN;
        if (c >= 1)        return M_COUNT;
        return a ? M_ARMED : M_IDLE;
    endfunction

    // Model: k counts cycles since entering the current mode; the blink
    // phase and walk position are plain divisions of k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode   = M_IDLE;
            m_k      = 0;
            exp_leds = 4'd0;
            exp_boom = 1'b0;
        end else begin
            m_ns = mode_rule(m_mode, int'(cnt_in), armed, ack);
            if (m_ns != m_mode) m_k = 0;
            else m_k++;
            m_mode   = m_ns;
            exp_boom = (m_mode == M_BOOM);
            case (m_mode)
                M_ARMED: exp_leds = 4'(1 << ((m_k / BH) % 4));
                M_COUNT: exp_leds = cnt_in;
                M_WARN:  exp_leds = (((m_k / BH) % 2) == 0) ? cnt_in : 4'd0;
                M_BOOM:  exp_leds = (((m_k / BH) % 2) == 0) ? 4'hF : 4'd0;
                default: exp_leds = 4'd0;
            endcase
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_leds", int'(leds), int'(exp_leds));
            chk("model_boom", int'(boom), int'(exp_boom));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int r;
        // Reset with random inputs
        #3;
        rst_n  = 1'b0;
        cnt_in = 4'($urandom_range(0, 15));
        armed  = 1'($urandom_range(0, 1));
        ack    = 1'($urandom_range(0, 1));
        #1;
        chk("rst_async_leds", int'(leds), 0);
        chk("rst_async_boom", int'(boom), 0);
        repeat (3) begin
            @(negedge clk);
            cnt_in = 4'($urandom_range(0, 15));
            armed  = 1'($urandom_range(0, 1));
            ack    = 1'($urandom_range(0, 1));
            chk("rst_hold_leds", int'(leds), 0);
        end
        @(negedge clk);
        cnt_in = 4'd0; armed = 1'b0; ack = 1'b0; rst_n = 1'b1;
        cyc(2);
        chk("idle_leds", int'(leds), 0);
        chk("idle_boom", int'(boom), 0);

        // Armed walk
        armed = 1'b1;
        cyc(1); chk("walk_0001", int'(leds), 1);
        cyc(3); chk("walk_0001_hold", int'(leds), 1);
        cyc(1); chk("walk_0010", int'(leds), 2);
        cyc(4); chk("walk_0100", int'(leds), 4);
        cyc(4); chk("walk_1000", int'(leds), 8);
        cyc(4); chk("walk_wrap", int'(leds), 1);

        // Count to warn
        armed = 1'b0; cnt_in = 4'd3;
        cyc(1); chk("count_3", int'(leds), 3);
        cnt_in = 4'd6;
        cyc(1); chk("count_6", int'(leds), 6);
        cyc(5); chk("count_6_steady", int'(leds), 6);
        cnt_in = 4'd7;
        cyc(1); chk("warn_on", int'(leds), 7);
        cyc(3); chk("warn_on_end", int'(leds), 7);
        cyc(1); chk("warn_off", int'(leds), 0);
        cyc(3); chk("warn_off_end", int'(leds), 0);
        cyc(1); chk("warn_on_again", int'(leds), 7);
        cyc(2);
        cnt_in = 4'd8;
        cyc(1); chk("warn_value_update", int'(leds), 8);
        cyc(1); chk("warn_no_restart", int'(leds), 0);

        // Terminal latch
        cnt_in = 4'd10;
        cyc(1); chk("boom_set", int'(boom), 1); chk("boom_flash_on", int'(leds), 15);
        cyc(4); chk("boom_flash_off", int'(leds), 0); chk("boom_still", int'(boom), 1);
        cnt_in = 4'd0; ack = 1'b0;
        cyc(3); chk("boom_latched", int'(boom), 1);
        ack = 1'b1; cnt_in = 4'd10;
        cyc(2); chk("boom_ack_at_term", int'(boom), 1);
        cnt_in = 4'd0;
        cyc(1); chk("ack_exit_boom", int'(boom), 0); chk("ack_exit_leds", int'(leds), 0);
        ack = 1'b0;

        // Ack outside BOOM
        cnt_in = 4'd5;
        cyc(1);
        ack = 1'b1;
        cyc(3); chk("count_ack_leds", int'(leds), 5); chk("count_ack_boom", int'(boom), 0);
        ack = 1'b0;

        // Async reset mid-flash
        cnt_in = 4'd12;
        cyc(1); chk("boom_above_term", int'(boom), 1); chk("boom_above_leds", int'(leds), 15);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_boom_leds", int'(leds), 0);
        chk("rst_mid_boom_boom", int'(boom), 0);
        cnt_in = 4'd0; armed = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2); chk("post_rst_leds", int'(leds), 0); chk("post_rst_boom", int'(boom), 0);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 70)      cnt_in = cnt_in;
            else if (r < 82) cnt_in = 4'd0;
            else if (r < 90) cnt_in = 4'($urandom_range(CM, 15));
            else             cnt_in = 4'($urandom_range(1, CM - 1));
            ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) armed = ~armed;
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
